// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with a 2-FF input synchroniser.
// It supports configurable data width, parity and stop-bit count, and it
// rejects glitches on the start bit.
//
// Output handshake: RxData/RxValid and the status flags form one word.
// A transfer happens on a rising Clk edge where RxValid & RxReady are both 1.
// While RxValid is high and RxReady is low, the word and its flags do not change.
// DbgState exposes the FSM encoding (0 IDLE, 1 START, 2 DATA, 3 PARITY,
// 4 STOP, 5 WAIT_HI).
module uart_rx_ovs #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Tick,
  input  logic              RxEn,
  input  logic              Rx,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              FrameErr,
  output logic              ParityErr,
  output logic              Break,
  output logic              Overrun,
  output logic              Busy,
  output logic [2:0]        DbgState
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] CNT_MID   = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(OVS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic              rx_q1, rx_s;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              fe_q, pe_q, one_seen_q;

  logic mid_hit, end_hit, last_data, last_stop, abort;
  logic frame_done, fe_final, brk_final, can_load, par_x;

  // Two-flop synchroniser on the asynchronous line; it resets to idle-high.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= Rx;
      rx_s  <= rx_q1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; dropping RxEn aborts any frame in progress.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (RxEn && !rx_s) state_d = S_START;
        S_START:   if (mid_hit) state_d = rx_s ? S_IDLE : S_DATA;
        S_DATA:    if (end_hit && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY:  if (end_hit) state_d = S_STOP;
        S_STOP:    if (frame_done) state_d = fe_final ? S_WAIT_HI : S_IDLE;
        S_WAIT_HI: if (rx_s) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and sample strobes decoded from the state and the tick counter.
  always_comb begin
    mid_hit    = Tick && (cnt_q == CNT_MID);
    end_hit    = Tick && (cnt_q == CNT_END);
    last_data  = (bit_idx_q == LAST_DATA);
    last_stop  = (bit_idx_q == LAST_STOP);
    abort      = (state_q != S_IDLE) && !RxEn;
    frame_done = !abort && (state_q == S_STOP) && end_hit && last_stop;
    // The final stop sample is folded in directly; it is never registered.
    fe_final   = fe_q | ~rx_s;
    brk_final  = ~(one_seen_q | rx_s);
    can_load   = !RxValid || RxReady;
    par_x      = (^shift_q) ^ rx_s;
    Busy       = (state_q != S_IDLE);
    DbgState   = state_q;
  end

  // Bit timing, shift register and per-frame error accumulation.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      one_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q      <= '0;
          bit_idx_q  <= '0;
          fe_q       <= 1'b0;
          pe_q       <= 1'b0;
          one_seen_q <= 1'b0;
        end
        S_START: begin
          if (Tick) cnt_q <= mid_hit ? '0 : cnt_q + 1'b1;
        end
        S_DATA, S_PARITY, S_STOP: begin
          if (Tick) cnt_q <= end_hit ? '0 : cnt_q + 1'b1;
          if (end_hit) begin
            one_seen_q <= one_seen_q | rx_s;
            if (state_q == S_DATA) begin
              shift_q   <= {rx_s, shift_q[DATA_W-1:1]};
              bit_idx_q <= last_data ? '0 : bit_idx_q + 1'b1;
            end else if (state_q == S_PARITY) begin
              pe_q <= (PARITY == 1) ? par_x : ~par_x;
            end else begin
              fe_q      <= fe_q | ~rx_s;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output word register, valid/ready handshake and sticky overrun flag.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      RxData    <= '0;
      RxValid   <= 1'b0;
      FrameErr  <= 1'b0;
      ParityErr <= 1'b0;
      Break     <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (frame_done && can_load) begin
        RxData    <= shift_q;
        RxValid   <= 1'b1;
        FrameErr  <= fe_final;
        ParityErr <= pe_q;
        Break     <= brk_final;
      end else if (RxValid && RxReady) begin
        RxValid <= 1'b0;
      end
      if (!RxEn) Overrun <= 1'b0;
      else if (frame_done && !can_load) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed bench for three receiver configurations.
// Configuration A is 8N1, B is 7 data bits with even parity, and C uses 2 stop bits.
// Tick runs every other Clk. One bit time is therefore 2*OVS Clk cycles.
module tb_uart_rx_ovs;

  localparam int OVS_T = 16;
  localparam int BIT_CLKS = 2 * OVS_T;

  // ---------------- clock / reset / shared stimulus ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic Tick = 1'b0;
  logic rx_en = 1'b1;
  logic rx_ready = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  always #5 Clk = ~Clk;
  always @(negedge Clk) Tick = ~Tick;

  logic [7:0] data_a;
  logic       valid_a, fe_a, pe_a, brk_a, ovr_a, busy_a;
  logic [2:0] st_a;
  logic [6:0] data_b;
  logic       valid_b, fe_b, pe_b, brk_b, ovr_b, busy_b;
  logic [2:0] st_b;
  logic [7:0] data_c;
  logic       valid_c, fe_c, pe_c, brk_c, ovr_c, busy_c;
  logic [2:0] st_c;

  uart_rx_ovs #(.DATA_W(8), .OVS(OVS_T), .PARITY(0), .STOP_BITS(1)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(rx_en), .Rx(rx_a),
    .RxData(data_a), .RxValid(valid_a), .RxReady(rx_ready),
    .FrameErr(fe_a), .ParityErr(pe_a), .Break(brk_a), .Overrun(ovr_a),
    .Busy(busy_a), .DbgState(st_a));

  uart_rx_ovs #(.DATA_W(7), .OVS(OVS_T), .PARITY(1), .STOP_BITS(1)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(rx_en), .Rx(rx_b),
    .RxData(data_b), .RxValid(valid_b), .RxReady(rx_ready),
    .FrameErr(fe_b), .ParityErr(pe_b), .Break(brk_b), .Overrun(ovr_b),
    .Busy(busy_b), .DbgState(st_b));

  uart_rx_ovs #(.DATA_W(8), .OVS(OVS_T), .PARITY(0), .STOP_BITS(2)) dut_c (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(rx_en), .Rx(rx_c),
    .RxData(data_c), .RxValid(valid_c), .RxReady(rx_ready),
    .FrameErr(fe_c), .ParityErr(pe_c), .Break(brk_c), .Overrun(ovr_c),
    .Busy(busy_c), .DbgState(st_c));

  // ---------------- monitors: handshake counts and captured words ----------------
  int hs_a = 0, hs_b = 0, hs_c = 0, saw_data_a = 0;
  logic [7:0] last_a = '0, prev_a = '0;

  always @(posedge Clk) begin
    if (valid_a && rx_ready) begin
      hs_a   <= hs_a + 1;
      last_a <= data_a;
      prev_a <= last_a;
    end
    if (valid_b && rx_ready) hs_b <= hs_b + 1;
    if (valid_c && rx_ready) hs_c <= hs_c + 1;
    if (st_a == 3'd2) saw_data_a <= saw_data_a + 1;
  end

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Send n bits LSB first, one bit time each, then leave the line idle-high.
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive_rx(which, bits[i]);
      repeat (BIT_CLKS) @(negedge Clk);
    end
    drive_rx(which, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge Clk);
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
    checks++; if ({fe_a, pe_a, brk_a, ovr_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {fe_a, pe_a, brk_a, ovr_a}); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st_a); end
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_basic;
    bit found;
    logic prev_busy;
    int hs0;
    hs0 = hs_a;
    send_bits(0, 16'({8'hA5, 1'b0}), 9);
    found = 1'b0;
    prev_busy = busy_a;
    for (int i = 0; i < 4 * OVS_T && !found; i++) begin
      @(negedge Clk);
      if (valid_a === 1'b1) found = 1'b1;
      else prev_busy = busy_a;
    end
    checks++; if (!found) begin errors++; $display("FAIL basic_valid_timeout got 0 want 1"); end
    checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", data_a); end
    checks++; if ({fe_a, pe_a, brk_a, ovr_a} !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b want 0000", {fe_a, pe_a, brk_a, ovr_a}); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy_a); end
    checks++; if (prev_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_before got %b want 1", prev_busy); end
    @(negedge Clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %b want 0", valid_a); end
    repeat (BIT_CLKS) @(negedge Clk);
    checks++; if (hs_a - hs0 !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", hs_a - hs0); end
  endtask

  task automatic test_back_to_back;
    int hs0;
    hs0 = hs_a;
    // First frame gets a 3/4-bit stop, then the next start bit follows at once.
    send_bits(0, 16'({8'h12, 1'b0}), 9);
    repeat (BIT_CLKS * 3 / 4) @(negedge Clk);
    send_bits(0, 16'({1'b1, 8'h34, 1'b0}), 10);
    repeat (BIT_CLKS) @(negedge Clk);
    checks++; if (hs_a - hs0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", hs_a - hs0); end
    checks++; if (prev_a !== 8'h12) begin errors++; $display("FAIL b2b_first got %h want 12", prev_a); end
    checks++; if (last_a !== 8'h34) begin errors++; $display("FAIL b2b_second got %h want 34", last_a); end
  endtask

  task automatic test_glitch;
    int hs0, sd0;
    hs0 = hs_a;
    sd0 = saw_data_a;
    rx_a = 1'b0;
    repeat (8) @(negedge Clk);
    checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL glitch_start got %0d want 1", st_a); end
    rx_a = 1'b1;
    repeat (24) @(negedge Clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy_a); end
    checks++; if (saw_data_a - sd0 !== 0) begin errors++; $display("FAIL glitch_data_state got %0d want 0", saw_data_a - sd0); end
    checks++; if (hs_a - hs0 !== 0 || valid_a !== 1'b0) begin errors++; $display("FAIL glitch_valid got %0d/%b want 0/0", hs_a - hs0, valid_a); end
  endtask

  task automatic test_parity;
    int hs0;
    hs0 = hs_b;
    send_bits(1, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10);
    checks++; if (data_b !== 7'h41) begin errors++; $display("FAIL par1_data got %h want 41", data_b); end
    checks++; if (pe_b !== 1'b1) begin errors++; $display("FAIL par1_err got %b want 1", pe_b); end
    checks++; if (fe_b !== 1'b0) begin errors++; $display("FAIL par1_fe got %b want 0", fe_b); end
    send_bits(1, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10);
    checks++; if (pe_b !== 1'b0) begin errors++; $display("FAIL par0_err got %b want 0", pe_b); end
    checks++; if (hs_b - hs0 !== 2) begin errors++; $display("FAIL par_count got %0d want 2", hs_b - hs0); end
  endtask

  task automatic test_break;
    int hs0;
    hs0 = hs_a;
    rx_a = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge Clk);
    checks++; if (hs_a - hs0 !== 1) begin errors++; $display("FAIL break_count got %0d want 1", hs_a - hs0); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL break_data got %h want 00", data_a); end
    checks++; if ({fe_a, brk_a, pe_a} !== 3'b110) begin errors++; $display("FAIL break_flags got %b want 110", {fe_a, brk_a, pe_a}); end
    checks++; if (st_a !== 3'd5) begin errors++; $display("FAIL break_wait_hi got %0d want 5", st_a); end
    rx_a = 1'b1;
    repeat (BIT_CLKS) @(negedge Clk);
    checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL break_idle got %0d want 0", st_a); end
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
    checks++; if (data_a !== 8'h3C) begin errors++; $display("FAIL break_next_data got %h want 3c", data_a); end
    checks++; if ({fe_a, brk_a} !== 2'b00) begin errors++; $display("FAIL break_next_flags got %b want 00", {fe_a, brk_a}); end
    checks++; if (hs_a - hs0 !== 2) begin errors++; $display("FAIL break_total got %0d want 2", hs_a - hs0); end
  endtask

  task automatic test_overrun;
    int hs0;
    hs0 = hs_a;
    rx_ready = 1'b0;
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", valid_a); end
    checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL ovr_data got %h want 11", data_a); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", ovr_a); end
    rx_ready = 1'b1;
    @(negedge Clk);
    rx_ready = 1'b0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovr_pop got %b want 0", valid_a); end
    checks++; if (hs_a - hs0 !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", hs_a - hs0); end
    @(negedge Clk);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", ovr_a); end
    rx_ready = 1'b1;
  endtask

  task automatic test_stop2;
    int hs0;
    hs0 = hs_c;
    send_bits(2, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11);
    checks++; if (data_c !== 8'h5A) begin errors++; $display("FAIL stop2_data got %h want 5a", data_c); end
    checks++; if ({fe_c, brk_c} !== 2'b10) begin errors++; $display("FAIL stop2_fe got %b want 10", {fe_c, brk_c}); end
    repeat (BIT_CLKS) @(negedge Clk);
    send_bits(2, 16'({2'b11, 8'hC3, 1'b0}), 11);
    checks++; if (data_c !== 8'hC3 || fe_c !== 1'b0) begin errors++; $display("FAIL stop2_good got %h/%b want c3/0", data_c, fe_c); end
    checks++; if (hs_c - hs0 !== 2) begin errors++; $display("FAIL stop2_count got %0d want 2", hs_c - hs0); end
  endtask

  task automatic test_rxen_abort;
    int hs0;
    hs0 = hs_a;
    send_bits(0, 16'({3'b101, 1'b0}), 4);
    checks++; if (st_a !== 3'd2) begin errors++; $display("FAIL abort_in_data got %0d want 2", st_a); end
    rx_en = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (st_a !== 3'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL abort_idle got %0d/%b want 0/0", st_a, busy_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL abort_ovr_clear got %b want 0", ovr_a); end
    checks++; if (valid_a !== 1'b0 || data_a !== 8'h11) begin errors++; $display("FAIL abort_hold got %b/%h want 0/11", valid_a, data_a); end
    send_bits(0, 16'({1'b1, 5'b10100}), 6);
    rx_en = 1'b1;
    repeat (BIT_CLKS) @(negedge Clk);
    checks++; if (hs_a - hs0 !== 0 || st_a !== 3'd0) begin errors++; $display("FAIL abort_no_frame got %0d/%0d want 0/0", hs_a - hs0, st_a); end
  endtask

  task automatic test_reset_mid;
    rx_ready = 1'b0;
    send_bits(0, 16'({1'b1, 8'h7E, 1'b0}), 10);
    checks++; if (valid_a !== 1'b1 || data_a !== 8'h7E) begin errors++; $display("FAIL rstmid_pre got %b/%h want 1/7e", valid_a, data_a); end
    send_bits(0, 16'({4'b1010, 1'b0}), 5);
    Rst_n = 1'b0;
    @(negedge Clk);
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid_a); end
    checks++; if ({fe_a, pe_a, brk_a, ovr_a} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b want 0000", {fe_a, pe_a, brk_a, ovr_a}); end
    checks++; if (busy_a !== 1'b0 || st_a !== 3'd0) begin errors++; $display("FAIL rstmid_state got %b/%0d want 0/0", busy_a, st_a); end
    Rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_stop2();
    test_rxen_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised oversampling UART receiver for the Bluetooth serial link. It replaces the fixed 8-bit receiver. It adds configurable data width, parity, stop-bit count, start-bit glitch rejection and an input synchroniser. It also provides a valid/ready output handshake with frame, parity, overrun and break reporting. It sits between the baud-tick generator and the game-command decoder, fully synchronous to `Clk`.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `OVS`, 16: Tick pulses per bit period, even, legal 4..32.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `Clk`  in  1  system clock; all state updates on rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `Tick`  in  1  one-`Clk`-wide enable pulse at OVS × baud rate (clock enable, never a clock).
- `RxEn`  in  1  receiver enable; low aborts any frame in progress.
- `Rx`  in  1  asynchronous serial line, idle high.
- `RxData`  out  DATA_W  received word, first-received bit in `RxData[0]`.
- `RxValid`  out  1  word held in `RxData` is valid.
- `RxReady`  in  1  consumer accepts; transfer occurs when `RxValid & RxReady`.
- `FrameErr`  out  1  held word had a zero stop bit.
- `ParityErr`  out  1  held word failed the parity check (always 0 when PARITY=0).
- `Break`  out  1  held word was all zeros, including parity and stop bits.
- `Overrun`  out  1  sticky flag: a completed frame was dropped.
- `Busy`  out  1  state is not IDLE.

## Operation
- `Rx` passes through a 2-FF synchroniser (both FFs reset to 1); the result is `rx_s`.
- Counter `cnt` is $clog2(OVS) bits wide and advances only on `Tick`. The bit index is $clog2(DATA_W+2) bits wide.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP and WAIT_HI.
- IDLE:
  - If `RxEn & !rx_s`, go to START with `cnt`=0.
- START:
  - On the Tick where `cnt`==OVS/2-1, check `rx_s`.
  - If `rx_s`=1, treat it as a glitch: return to IDLE with no output.
  - Otherwise set `cnt`=0, bit index=0, and go to DATA.
- DATA:
  - On the Tick where `cnt`==OVS-1, sample `rx_s`, shift it in LSB-first, and set `cnt`=0.
  - After DATA_W samples, go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - Take one sample.
  - Even: error if XOR(data, parity bit)=1. Odd: error if XOR(data, parity bit)=0.
- STOP:
  - Take STOP_BITS samples; any zero sample sets the frame error.
  - The frame completes on the Tick of the last stop sample; it does not wait for the end of the bit.
- On completion:
  - If `RxValid`=0, or `RxReady`=1 in the same cycle: load `RxData`, `FrameErr`, `ParityErr` and `Break`, and set `RxValid`=1.
  - Otherwise drop the new frame, leave the held word unchanged, and set `Overrun`=1.
  - Next state is WAIT_HI if the frame error is set, else IDLE.
- WAIT_HI: hold until `rx_s`=1, then go to IDLE. This ensures a held-low line yields exactly one frame.
- `RxValid` clears on the cycle after `RxValid & RxReady`, unless a new load occurs in that same cycle.
- The error flags and `Break` change only on a load.
- `RxEn`=0 in any state other than IDLE:
  - Next state is IDLE; the partial frame is discarded.
  - `RxValid` and `RxData` are held.
  - `Overrun` clears.
- `Overrun` clears only on reset or `RxEn`=0.

## Timing
- Reset values: `RxData`=0, `RxValid`=0, `FrameErr`=0, `ParityErr`=0, `Break`=0, `Overrun`=0, `Busy`=0, FSM=IDLE.
- Reset asserted mid-frame reaches all of these values at the next `Clk` edge.
- `rx_s` lags `Rx` by 2 `Clk` cycles.
- Last sample is taken OVS/2 + OVS×(DATA_W + (PARITY≠0) + STOP_BITS) Ticks after START is entered.
- `RxValid` rises 1 `Clk` after the Tick of the last sample.
- `Tick` high in consecutive `Clk` cycles is legal; each pulse counts once.
- Back-to-back frames: the next start bit is detected in IDLE immediately after completion. No idle gap is required beyond the remaining half of the stop bit.

## Test plan
- Defaults; send 0xA5 8N1 → one `RxValid`, `RxData`=0xA5, all error flags 0, `Busy` low 1 `Clk` after completion.
- `Rx` low for 4 Ticks, then high → no START-to-DATA transition, `RxValid` stays 0, `Busy` back to 0 after OVS/2 Ticks.
- DATA_W=7, PARITY=1; send 0x41 with parity bit 1 → `RxData`=0x41, `ParityErr`=1. Resend with parity bit 0 → `ParityErr`=0.
- `Rx` held low for 20 bit times, then high, then 0x3C → first frame `RxData`=0, `FrameErr`=1, `Break`=1. No second frame while low. Then `RxData`=0x3C with no errors.
- `RxReady`=0; send 0x11 then 0x22 → `RxData` stays 0x11, `Overrun`=1. Pulse `RxReady` → `RxValid`=0 next cycle.
- STOP_BITS=2, second stop bit 0 → `FrameErr`=1.
- `RxEn` dropped mid-DATA → no `RxValid`, FSM=IDLE.
- `Rst_n` low mid-frame → all outputs at reset values after 1 edge.
